debounce_pair: RTL and testbench
================================

Name: debounce_pair

Overview:
- Upstream conditioning stage for the two-input logic gates (AND/OR/XOR).
- Takes two raw, asynchronous one-bit inputs (switches/buttons) and produces clean, glitch-free one-bit signals `a` and `b` that connect directly to the gate's `a`/`b` inputs.
- Each channel is synchronized, debounced by a stability counter, and flagged with one-cycle edge pulses.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles a changed level must persist before the output follows. Legal range 1..2^CNT_W-1.
- CNT_W, 3: width of each channel's stability counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- raw_a  input  1  raw asynchronous input, channel A.
- raw_b  input  1  raw asynchronous input, channel B.
- a  output  1  debounced level, channel A. Feeds gate input `a`.
- b  output  1  debounced level, channel B. Feeds gate input `b`.
- a_rise  output  1  one-cycle pulse when `a` goes 0->1.
- a_fall  output  1  one-cycle pulse when `a` goes 1->0.
- b_rise  output  1  one-cycle pulse when `b` goes 0->1.
- b_fall  output  1  one-cycle pulse when `b` goes 1->0.
- both_stable  output  1  high when neither channel has a pending change.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchronizer flops, counters, a, b and all pulses clear to 0.
  - both_stable reads 1 while reset is held.
  - Asserting reset mid-count discards the pending change.
- Synchronizer: per channel, a 2-flop chain raw -> s1 -> s2; only s2 is used downstream.
- Per-channel state machine (A and B are identical and independent):
  - STABLE (cnt == 0, s2 == out):
    - If s2 != out: go to COUNTING, cnt <= 1. If STABLE_CYCLES == 1, instead commit immediately (see commit).
  - COUNTING:
    - If s2 == out (bounce back): cnt <= 0, return to STABLE, no output change, no pulse.
    - Else if cnt == STABLE_CYCLES-1: commit.
    - Else: cnt <= cnt+1.
  - Commit: out <= s2, cnt <= 0, return to STABLE. In the same cycle, assert the rise pulse (s2 == 1) or fall pulse (s2 == 0) for exactly one cycle.
- Latency: a raw level first captured by s1 at edge N appears on the output at edge N+1+STABLE_CYCLES. With defaults, that is 5 edges after capture.
- Pulses are registered and aligned with the output transition. Rise and fall for the same channel are never high together.
- A bounce that lasts fewer than STABLE_CYCLES synchronized cycles never reaches the output. Repeated glitches each restart the count from 0.
- Simultaneous changes on A and B are handled independently. If both commit on the same edge, both pulses fire together, and the downstream gate sees both inputs change in that one cycle.
- both_stable = (cnt_a == 0) && (s2_a == a) && (cnt_b == 0) && (s2_b == b). Combinational from registers only; no combinational path from raw_* to any output.
- Counters never wrap: the maximum count value is STABLE_CYCLES-1. A parameter combination that violates the legal range is a configuration error, flagged by an elaboration-time check.

Test Plan:
- Reset: assert reset for 3 cycles with raw_a=raw_b=1 -> a=b=0, all pulses 0, both_stable=1. Release -> a=1 exactly 6 edges later, with a_rise high for that one cycle only.
- Clean step: raw_a 0->1 held, STABLE_CYCLES=4 -> a rises 6 edges after the change, a_rise pulses once. raw_a 1->0 -> a_fall pulses once and a=0 after the same delay.
- Bounce rejection: raw_b toggles 1,0,1,0 every 2 cycles, then settles at 1 -> b stays 0 throughout the toggling and rises only 6 edges after settling. Exactly one b_rise.
- Short glitch: raw_a high for 3 cycles then low -> a never changes, no pulses, both_stable returns to 1.
- Simultaneous: raw_a and raw_b both 0->1 on the same edge -> a and b rise on the same edge, a_rise and b_rise both pulse that cycle, and the downstream AND output rises one cycle-aligned with them.
- Reset mid-count: raw_a 0->1, assert reset 2 edges after s2_a changes -> a remains 0, no a_rise. After release, the full 6-edge delay restarts.

Source files
------------

// File: rtl/debounce_pair.sv
// Two independent synchronize-and-debounce channels conditioning raw switch
// inputs for a two-input gate, with registered edge pulses and a stability flag.

module debounce_chan #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic out,
    output logic rise,
    output logic fall,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // cnt == 0 with s2 == out is the idle state; a nonzero cnt means a change is pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // With STABLE_CYCLES == 1 this fires straight from the idle state
                out  <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = (cnt == '0) && (s2 == out);

endmodule

module debounce_pair #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic both_stable
);

    logic stable_a;
    logic stable_b;

    // The counter must be able to hold STABLE_CYCLES-1 without wrapping
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("debounce_pair: STABLE_CYCLES out of range for CNT_W");
    end

    debounce_chan #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_a),
        .out   (a),
        .rise  (a_rise),
        .fall  (a_fall),
        .stable(stable_a)
    );

    debounce_chan #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_b),
        .out   (b),
        .rise  (b_rise),
        .fall  (b_fall),
        .stable(stable_b)
    );

    assign both_stable = stable_a && stable_b;

endmodule

// File: tb/tb_debounce_pair.sv
// Directed, table-driven bench for debounce_pair with hand-computed per-edge
// expectations plus sequences for reset, simultaneous changes and mid-count reset.

module tb_debounce_pair;

    logic clk = 1'b0;
    logic reset;
    logic raw_a;
    logic raw_b;
    logic a, b, a_rise, a_fall, b_rise, b_fall, both_stable;
    logic gate_and;
    logic [6:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [6:0] exp;   // {a, b, a_rise, a_fall, b_rise, b_fall, both_stable}
    } vec_t;

    vec_t tbl[$];

    debounce_pair #(
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_a      (raw_a),
        .raw_b      (raw_b),
        .a          (a),
        .b          (b),
        .a_rise     (a_rise),
        .a_fall     (a_fall),
        .b_rise     (b_rise),
        .b_fall     (b_fall),
        .both_stable(both_stable)
    );

    always #5 clk = ~clk;

    assign gate_and = a & b;
    assign obs      = {a, b, a_rise, a_fall, b_rise, b_fall, both_stable};

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {a,b,ar,af,br,bf,bs}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic ra, input logic rb, input logic ea, input logic eb,
                       input logic ear, input logic eaf, input logic ebr, input logic ebf,
                       input logic ebs);
        vec_t v;
        v.ra  = ra;
        v.rb  = rb;
        v.exp = {ea, eb, ear, eaf, ebr, ebf, ebs};
        tbl.push_back(v);
    endtask

    // Reset held for n edges with the current raw levels; released 1 time unit after an edge
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Both raw inputs are high from the edge after entry; both outputs commit on the 6th edge
    task automatic both_rise_seq(input string name);
        logic [6:0] e;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)      e = 7'b0000001;
            else if (k < 6)  e = 7'b0000000;
            else if (k == 6) e = 7'b1110101;
            else             e = 7'b1100001;
            check($sformatf("%s_edge%0d", name, k), obs, e);
            if (k == 5) check_bit($sformatf("%s_and_e5", name), gate_and, 1'b0);
            if (k == 6) check_bit($sformatf("%s_and_e6", name), gate_and, 1'b1);
        end
    endtask

    initial begin
        // Clean step on A, then fall, then a 3-cycle glitch (cnt peaks at 3, no commit)
        add(1,0, 0,0,0,0,0,0,1);
        add(1,0, 0,0,0,0,0,0,0);
        add(1,0, 0,0,0,0,0,0,0);
        add(1,0, 0,0,0,0,0,0,0);
        add(1,0, 0,0,0,0,0,0,0);
        add(1,0, 1,0,1,0,0,0,1);
        add(1,0, 1,0,0,0,0,0,1);
        add(1,0, 1,0,0,0,0,0,1);
        add(0,0, 1,0,0,0,0,0,1);
        add(0,0, 1,0,0,0,0,0,0);
        add(0,0, 1,0,0,0,0,0,0);
        add(0,0, 1,0,0,0,0,0,0);
        add(0,0, 1,0,0,0,0,0,0);
        add(0,0, 0,0,0,1,0,0,1);
        add(0,0, 0,0,0,0,0,0,1);
        add(0,0, 0,0,0,0,0,0,1);
        add(1,0, 0,0,0,0,0,0,1);
        add(1,0, 0,0,0,0,0,0,0);
        add(1,0, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,1);
        add(0,0, 0,0,0,0,0,0,1);
        add(0,0, 0,0,0,0,0,0,1);
        add(0,0, 0,0,0,0,0,0,1);
        // Bounce on B: 1,1,0,0,1,1,0,0 then settle high
        add(0,1, 0,0,0,0,0,0,1);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,1, 0,0,0,0,0,0,1);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,0, 0,0,0,0,0,0,0);
        add(0,1, 0,0,0,0,0,0,1);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,1, 0,0,0,0,0,0,0);
        add(0,1, 0,1,0,0,1,0,1);
        add(0,1, 0,1,0,0,0,0,1);
        add(0,1, 0,1,0,0,0,0,1);
        add(0,1, 0,1,0,0,0,0,1);

        // Reset with both raw inputs high, then release
        raw_a = 1'b1;
        raw_b = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", obs, 7'b0000001);
        reset = 1'b0;
        both_rise_seq("reset_release");

        // Table section starts from a cleared, quiet state
        raw_a = 1'b0;
        raw_b = 1'b0;
        do_reset(2);
        for (int i = 0; i < tbl.size(); i++) begin
            raw_a = tbl[i].ra;
            raw_b = tbl[i].rb;
            @(posedge clk);
            #1;
            check($sformatf("tbl_row%0d", i), obs, tbl[i].exp);
        end

        // Simultaneous rise on both channels
        raw_a = 1'b0;
        raw_b = 1'b0;
        do_reset(2);
        raw_a = 1'b1;
        raw_b = 1'b1;
        both_rise_seq("simul");

        // Reset two edges after s2_a changes discards the pending change
        raw_a = 1'b0;
        raw_b = 1'b0;
        do_reset(2);
        raw_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("midcnt_pre%0d", k), obs, (k == 1) ? 7'b0000001 : 7'b0000000);
        end
        reset = 1'b1;
        #1;
        check("midcnt_async", obs, 7'b0000001);
        repeat (2) @(posedge clk);
        #1;
        check("midcnt_held", obs, 7'b0000001);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            logic [6:0] e;
            @(posedge clk);
            #1;
            if (k == 1)      e = 7'b0000001;
            else if (k < 6)  e = 7'b0000000;
            else if (k == 6) e = 7'b1010001;
            else             e = 7'b1000001;
            check($sformatf("midcnt_post%0d", k), obs, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
